// File: rtl/diff_ping_sched_if.sv
// diff_ping_sched_if
//   Bundles the control, channel-event and status signals of the ping
//   scheduler. clk/rst stay outside as plain ports on the scheduler.
//
//   Handshake semantics: there is no valid/ready pair on this block.
//   ack_event_i[k] and sigint_i[k] are single-cycle event strobes from the
//   channel's diff decoder, sampled on every rising clock edge. They only
//   have an effect while the scheduler is waiting for channel k to answer.
//   A ping is the level change of ping_o[k]; it carries no strobe.
//
//   Modports:
//     master : the controller side (drives enables, timing, events, clears)
//     slave  : the scheduler itself
//
//   Signals:
//     en_i          scheduler enable
//     ch_en_i       per-channel ping enable
//     wait_cyc_i    idle gap between pings
//     timeout_cyc_i ack window length
//     ack_event_i   decoder event per channel
//     sigint_i      decoder signal-integrity error per channel
//     clear_i       clear sticky fail bits
//     ping_o        ping level per channel
//     busy_o        scheduler is pinging or waiting for an ack
//     cur_ch_o      channel last selected
//     fail_pulse_o  one-cycle pulse on any failure
//     fail_o        sticky per-channel fail
//     fail_sigint_o cause of last failure (1 = sigint, 0 = timeout)
//     dbg_state_o   current FSM state (0 IDLE, 1 WAIT, 2 PING, 3 ACK)
interface diff_ping_sched_if #(
    parameter int NumCh  = 4,
    parameter int TimerW = 16
);
    localparam int ChW = $clog2(NumCh);

    logic              en_i;
    logic [NumCh-1:0]  ch_en_i;
    logic [TimerW-1:0] wait_cyc_i;
    logic [TimerW-1:0] timeout_cyc_i;
    logic [NumCh-1:0]  ack_event_i;
    logic [NumCh-1:0]  sigint_i;
    logic [NumCh-1:0]  clear_i;

    logic [NumCh-1:0]  ping_o;
    logic              busy_o;
    logic [ChW-1:0]    cur_ch_o;
    logic              fail_pulse_o;
    logic [NumCh-1:0]  fail_o;
    logic              fail_sigint_o;
    logic [1:0]        dbg_state_o;

    modport master (
        output en_i, ch_en_i, wait_cyc_i, timeout_cyc_i,
        output ack_event_i, sigint_i, clear_i,
        input  ping_o, busy_o, cur_ch_o, fail_pulse_o, fail_o, fail_sigint_o,
        input  dbg_state_o
    );

    modport slave (
        input  en_i, ch_en_i, wait_cyc_i, timeout_cyc_i,
        input  ack_event_i, sigint_i, clear_i,
        output ping_o, busy_o, cur_ch_o, fail_pulse_o, fail_o, fail_sigint_o,
        output dbg_state_o
    );
endinterface

// File: rtl/diff_ping_sched.sv
// diff_ping_sched
//   Round-robin ping scheduler for NumCh differentially encoded alert/ack
//   channels. Each selected channel gets its ping level toggled, then the
//   scheduler waits for that channel's decoder to report an ack event. A
//   missing ack (timeout) or a signal-integrity error during the window marks
//   the channel as failed (sticky) and raises a one-cycle failure pulse.
//
//   Ports:
//     clk_i  clock
//     rst_i  synchronous reset, active-high
//     bus    diff_ping_sched_if.slave (see the interface file for signals)
//
//   The NumCh/TimerW parameters must match those of the connected interface.
module diff_ping_sched #(
    parameter int NumCh  = 4,
    parameter int TimerW = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    diff_ping_sched_if.slave      bus
);
    localparam int ChW = $clog2(NumCh);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PING = 2'd2,
        S_ACK  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] cnt_q, cnt_d;
    logic [ChW-1:0]    last_ch_q, last_ch_d;
    logic [ChW-1:0]    cur_ch_q, cur_ch_d;
    logic [NumCh-1:0]  ping_q, ping_d;
    logic [NumCh-1:0]  fail_q, fail_d;
    logic              fail_pulse_q, fail_pulse_d;
    logic              fail_sigint_q, fail_sigint_d;

    logic [NumCh-1:0]  fail_set;
    logic              do_fail;
    logic              fail_cause;

    // Next channel: lowest enabled index strictly above last_ch, wrapping.
    // Scanning offsets from largest to smallest lets the smallest offset win.
    // Offset NumCh lands back on last_ch, so a single enabled channel is
    // pinged repeatedly.
    logic              nxt_found;
    logic [ChW-1:0]    nxt_ch;
    int                cand;

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        cand      = 0;
        for (int off = NumCh; off >= 1; off--) begin
            cand = (int'(last_ch_q) + off) % NumCh;
            if (bus.ch_en_i[ChW'(cand)]) begin
                nxt_found = 1'b1;
                nxt_ch    = ChW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_ch_q     <= ChW'(NumCh - 1);
            cur_ch_q      <= '0;
            ping_q        <= '0;
            fail_q        <= '0;
            fail_pulse_q  <= 1'b0;
            fail_sigint_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_ch_q     <= last_ch_d;
            cur_ch_q      <= cur_ch_d;
            ping_q        <= ping_d;
            fail_q        <= fail_d;
            fail_pulse_q  <= fail_pulse_d;
            fail_sigint_q <= fail_sigint_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_ch_d     = last_ch_q;
        cur_ch_d      = cur_ch_q;
        ping_d        = ping_q;
        fail_pulse_d  = 1'b0;
        fail_sigint_d = fail_sigint_q;
        fail_set      = '0;
        do_fail       = 1'b0;
        fail_cause    = 1'b0;

        if (!bus.en_i) begin
            // Disabling aborts any ping in flight without flagging it.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|bus.ch_en_i) begin
                        state_d = S_WAIT;
                        cnt_d   = bus.wait_cyc_i;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - TimerW'(1);
                    end else if (nxt_found) begin
                        state_d   = S_PING;
                        cur_ch_d  = nxt_ch;
                        last_ch_d = nxt_ch;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PING: begin
                    ping_d[cur_ch_q] = ~ping_q[cur_ch_q];
                    cnt_d            = bus.timeout_cyc_i;
                    state_d          = S_ACK;
                end
                S_ACK: begin
                    // sigint beats ack beats timeout; an ack in the last
                    // window cycle (cnt==0) still counts as a success.
                    if (bus.sigint_i[cur_ch_q]) begin
                        do_fail    = 1'b1;
                        fail_cause = 1'b1;
                    end else if (bus.ack_event_i[cur_ch_q]) begin
                        cnt_d   = bus.wait_cyc_i;
                        state_d = S_WAIT;
                    end else if (cnt_q == '0) begin
                        do_fail    = 1'b1;
                        fail_cause = 1'b0;
                    end else begin
                        cnt_d = cnt_q - TimerW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_fail) begin
            fail_pulse_d       = 1'b1;
            fail_set[cur_ch_q] = 1'b1;
            fail_sigint_d      = fail_cause;
            cnt_d              = bus.wait_cyc_i;
            state_d            = S_WAIT;
        end

        // A failure landing in the same cycle as its clear stays set.
        fail_d = (fail_q & ~bus.clear_i) | fail_set;
    end

    assign bus.ping_o        = ping_q;
    assign bus.busy_o        = (state_q == S_PING) || (state_q == S_ACK);
    assign bus.cur_ch_o      = cur_ch_q;
    assign bus.fail_pulse_o  = fail_pulse_q;
    assign bus.fail_o        = fail_q;
    assign bus.fail_sigint_o = fail_sigint_q;
    assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_diff_ping_sched.sv
// tb_diff_ping_sched
//   Bench for diff_ping_sched with NumCh=4. Inputs change on the falling
//   edge, outputs are read on the falling edge. Each ping is handled as one
//   transaction: expected channel, toggle time, resolution latency and sticky
//   fail state come either from a constant table or from a transaction-level
//   model of the scheduling rules.
module tb_diff_ping_sched;
    localparam int NCH = 4;
    localparam int TW  = 16;

    localparam int K_ACK  = 0;
    localparam int K_SIG  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    diff_ping_sched_if #(.NumCh(NCH), .TimerW(TW)) bus ();

    diff_ping_sched #(.NumCh(NCH), .TimerW(TW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [NCH-1:0] ping_seen;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    function automatic int next_ch(input int last, input logic [NCH-1:0] en);
        int c;
        for (int off = 1; off <= NCH; off++) begin
            c = (last + off) % NCH;
            if (en[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.en_i        = 1'b0;
        bus.ack_event_i = '0;
        bus.sigint_i    = '0;
        bus.clear_i     = '0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        ping_seen = '0;
    endtask

    // Waits for a ping level change, noising all event inputs meanwhile.
    // Returns at the falling edge of the first ACK cycle with events cleared.
    task automatic wait_toggle(input int limit, output int t, output logic [NCH-1:0] mask,
                               output bit ok);
        ok   = 1'b0;
        t    = 0;
        mask = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.ping_o !== ping_seen) begin
                t               = cyc;
                mask            = bus.ping_o ^ ping_seen;
                ping_seen       = bus.ping_o;
                bus.ack_event_i = '0;
                bus.sigint_i    = '0;
                ok              = 1'b1;
                break;
            end
            bus.ack_event_i = NCH'($urandom);
            bus.sigint_i    = NCH'($urandom);
        end
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL toggle_timeout: no ping toggle within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    // One ping transaction. The response is applied in ACK cycle k; lat is
    // the expected number of cycles from toggle to resolution.
    task automatic do_ping(input int exp_ch, input int exp_t, input int kind, input int k,
                           input int lat, input bit exp_ev, input bit exp_cause,
                           input logic [NCH-1:0] exp_fail, input bit clr_res,
                           output int r_edge, output bit ok);
        int t;
        logic [NCH-1:0] mk, m;
        r_edge = exp_t + lat;
        wait_toggle(exp_t - cyc + 6, t, mk, ok);
        if (ok) begin
            m = '0;
            m[exp_ch] = 1'b1;
            exp_q.push_back(32'(m));
            chk("ping_channel", mk, exp_q.pop_front());
            chk("ping_time", t, exp_t);
            chk("cur_ch", bus.cur_ch_o, exp_ch);
            for (int j = 0; j <= lat; j++) begin
                if (j < lat) begin
                    chk("busy_in_ack", bus.busy_o, 1);
                    chk("no_early_pulse", bus.fail_pulse_o, 0);
                    if (j == 0) begin
                        bus.ack_event_i = ~m;
                        bus.sigint_i    = ~m;
                    end else begin
                        bus.ack_event_i = NCH'($urandom) & ~m;
                        bus.sigint_i    = NCH'($urandom) & ~m;
                    end
                    if ((kind == K_ACK || kind == K_BOTH) && j == k) bus.ack_event_i |= m;
                    if ((kind == K_SIG || kind == K_BOTH) && j == k) bus.sigint_i |= m;
                    bus.clear_i = (clr_res && j == lat - 1) ? m : '0;
                    @(negedge clk);
                end else begin
                    chk("fail_pulse", bus.fail_pulse_o, exp_ev);
                    chk("fail_vec", bus.fail_o, exp_fail);
                    chk("fail_cause", bus.fail_sigint_o, exp_cause);
                    chk("busy_after", bus.busy_o, 0);
                    bus.ack_event_i = NCH'($urandom);
                    bus.sigint_i    = NCH'($urandom);
                    bus.clear_i     = clr_res ? m : '0;
                end
            end
            r_edge = t + lat;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NCH-1:0] ch_en;
        int             kind;
        int             k;
        int             ch;
        int             lat;
        bit             ev;
        bit             cause;
        logic [NCH-1:0] fail;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int r, c, t, w, to, last, ch, kind, k, lat;
        bit ok, ev, cause;
        logic [NCH-1:0] mk, ce, efail, held;

        // wait=2, timeout=3 throughout the table
        tbl[0]  = '{4'hF, K_ACK,  1, 0, 2, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{4'hF, K_ACK,  1, 1, 2, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{4'hF, K_ACK,  1, 2, 2, 1'b0, 1'b0, 4'h0};
        tbl[3]  = '{4'hF, K_ACK,  1, 3, 2, 1'b0, 1'b0, 4'h0};
        tbl[4]  = '{4'hF, K_ACK,  1, 0, 2, 1'b0, 1'b0, 4'h0};
        tbl[5]  = '{4'hA, K_NONE, 0, 1, 4, 1'b1, 1'b0, 4'h2};
        tbl[6]  = '{4'hA, K_NONE, 0, 3, 4, 1'b1, 1'b0, 4'hA};
        tbl[7]  = '{4'h4, K_BOTH, 1, 2, 2, 1'b1, 1'b1, 4'hE};
        tbl[8]  = '{4'hF, K_ACK,  3, 3, 4, 1'b0, 1'b1, 4'hE};
        tbl[9]  = '{4'hF, K_SIG,  0, 0, 1, 1'b1, 1'b1, 4'hF};
        tbl[10] = '{4'hF, K_ACK,  4, 1, 4, 1'b1, 1'b0, 4'hF};

        rst               = 1'b1;
        bus.en_i          = 1'b0;
        bus.ch_en_i       = '0;
        bus.wait_cyc_i    = '0;
        bus.timeout_cyc_i = '0;
        bus.ack_event_i   = '0;
        bus.sigint_i      = '0;
        bus.clear_i       = '0;
        do_reset();

        // reset state
        chk("rst_ping", bus.ping_o, 0);
        chk("rst_fail", bus.fail_o, 0);
        chk("rst_pulse", bus.fail_pulse_o, 0);
        chk("rst_cause", bus.fail_sigint_o, 0);
        chk("rst_cur_ch", bus.cur_ch_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_state", bus.dbg_state_o, 0);

        // table-driven round robin, timeouts, sigint priority, window edge
        bus.wait_cyc_i    = 16'd2;
        bus.timeout_cyc_i = 16'd3;
        bus.ch_en_i       = tbl[0].ch_en;
        bus.en_i          = 1'b1;
        t = cyc + 2 + 3;
        for (int i = 0; i < 11; i++) begin
            bus.ch_en_i = tbl[i].ch_en;
            do_ping(tbl[i].ch, t, tbl[i].kind, tbl[i].k, tbl[i].lat, tbl[i].ev,
                    tbl[i].cause, tbl[i].fail, 1'b0, r, ok);
            if (!ok) break;
            t = r + 2 + 2;
        end

        // en_i drop mid-ACK: back to IDLE, no pulse, ping and fail held
        wait_toggle(20, t, mk, ok);
        if (ok) begin
            chk("endrop_ch", mk, 4'b0100);
            held = bus.ping_o;
            @(negedge clk);
            bus.en_i = 1'b0;
            @(negedge clk);
            chk("endrop_busy", bus.busy_o, 0);
            chk("endrop_state", bus.dbg_state_o, 0);
            chk("endrop_pulse", bus.fail_pulse_o, 0);
            chk("endrop_ping", bus.ping_o, held);
            chk("endrop_fail", bus.fail_o, 4'hF);
            repeat (3) @(negedge clk);
            chk("endrop_ping_later", bus.ping_o, held);
            chk("endrop_pulse_later", bus.fail_pulse_o, 0);
            bus.en_i = 1'b1;
            // reset in the middle of the next ping's ack window
            wait_toggle(20, t, mk, ok);
            if (ok) begin
                chk("reen_ch", mk, 4'b1000);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                ping_seen = '0;
                chk("midrst_ping", bus.ping_o, 0);
                chk("midrst_fail", bus.fail_o, 0);
                chk("midrst_cur_ch", bus.cur_ch_o, 0);
                chk("midrst_busy", bus.busy_o, 0);
                chk("midrst_cause", bus.fail_sigint_o, 0);
                wait_toggle(20, t, mk, ok);
                if (ok) chk("after_rst_ch", mk, 4'b0001);
            end
        end

        // timeout=0: ack in the only window cycle passes, one later fails
        do_reset();
        bus.wait_cyc_i    = 16'd1;
        bus.timeout_cyc_i = 16'd0;
        bus.ch_en_i       = 4'b0001;
        bus.en_i          = 1'b1;
        do_ping(0, cyc + 1 + 3, K_ACK, 0, 1, 1'b0, 1'b0, 4'h0, 1'b0, r, ok);
        if (ok) do_ping(0, r + 1 + 2, K_ACK, 1, 1, 1'b1, 1'b0, 4'h1, 1'b0, r, ok);

        // clear coincident with a failure loses; clear alone next cycle wins
        do_reset();
        bus.wait_cyc_i    = 16'd0;
        bus.timeout_cyc_i = 16'd2;
        bus.ch_en_i       = 4'b0010;
        bus.en_i          = 1'b1;
        do_ping(1, cyc + 0 + 3, K_NONE, 0, 3, 1'b1, 1'b0, 4'h2, 1'b1, r, ok);
        if (ok) begin
            @(negedge clk);
            chk("clear_after", bus.fail_o, 4'h0);
            bus.clear_i = '0;
        end

        // randomized runs against the transaction-level model
        for (int run = 0; run < 24; run++) begin
            do_reset();
            ce = NCH'($urandom_range(1, 15));
            w  = $urandom_range(0, 4);
            to = $urandom_range(0, 5);
            bus.ch_en_i       = ce;
            bus.wait_cyc_i    = TW'(w);
            bus.timeout_cyc_i = TW'(to);
            bus.en_i          = 1'b1;
            last  = NCH - 1;
            efail = '0;
            cause = 1'b0;
            t = cyc + w + 3;
            for (int p = 0; p < 8; p++) begin
                ch   = next_ch(last, ce);
                kind = $urandom_range(0, 3);
                k    = $urandom_range(0, to + 1);
                ev   = 1'b0;
                if ((kind == K_SIG || kind == K_BOTH) && k <= to) begin
                    ev = 1'b1; cause = 1'b1; lat = k + 1;
                end else if (kind == K_ACK && k <= to) begin
                    lat = k + 1;
                end else begin
                    ev = 1'b1; cause = 1'b0; lat = to + 1;
                end
                if (ev) efail[ch] = 1'b1;
                do_ping(ch, t, kind, k, lat, ev, cause, efail, 1'b0, r, ok);
                if (!ok) break;
                t    = r + w + 2;
                last = ch;
            end
        end

        bus.en_i = 1'b0;
        c = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
